// File: rtl/wave_meter.sv
// wave_meter: hysteresis-comparator meter for frequency, period, high time and extremes per gate window (WAVE_METER_AUTO_THR_EN: adaptive threshold).
// Latency: sample to comparator state 1 cycle; result set and meas_valid 1 cycle after the window's last cycle.
// Backpressure: none; every sample_valid sample is consumed, results are published as a one-cycle strobe.
module wave_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned HYST        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    output logic [31:0] freq_cnt,
    output logic [31:0] period_cycles,
    output logic [31:0] high_cycles,
    output logic [7:0]  vmax,
    output logic [7:0]  vmin,
    output logic        meas_valid
);
    typedef struct packed {
        logic [31:0] freq;
        logic [31:0] period;
        logic [31:0] high;
        logic [7:0]  vmax;
        logic [7:0]  vmin;
    } meas_t;

    typedef enum logic {LVL_LOW, LVL_HIGH} lvl_t;

    localparam int unsigned   GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 2;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [8:0]    HYST9     = 9'(HYST);
    localparam logic [31:0]   SAT32     = 32'hFFFF_FFFF;
    localparam meas_t         MEAS_CLR  = '{freq: 32'd0, period: 32'd0, high: 32'd0,
                                            vmax: 8'h00, vmin: 8'hFF};

    logic [GW-1:0] gate;
    logic          window_end;
    logic [7:0]    thr;
    logic [7:0]    up_trip;
    logic [7:0]    lo_trip;
    logic [8:0]    up_sum;
    lvl_t          lvl;
    lvl_t          lvl_nxt;
    logic          rise_evt;
    logic          fall_evt;
    logic [31:0]   tmr;
    logic [31:0]   tmr_inc;
    logic          rise_seen;
    meas_t         run_q;
    meas_t         run_nxt;
    meas_t         res_q;

    assign window_end = (gate == GATE_LAST);

`ifdef WAVE_METER_AUTO_THR_EN
    logic       seen_run;
    logic [8:0] ext_sum;

    assign ext_sum = {1'b0, run_nxt.vmax} + {1'b0, run_nxt.vmin};

    // Midpoint of the closing window's extremes (including its last cycle) drives the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr      <= 8'd128;
            seen_run <= 1'b0;
        end else if (window_end) begin
            if (seen_run || sample_valid) begin
                thr <= ext_sum[8:1];
            end
            seen_run <= 1'b0;
        end else if (sample_valid) begin
            seen_run <= 1'b1;
        end
    end
`else
    assign thr = 8'd128;
`endif

    always_comb begin
        up_sum  = {1'b0, thr} + HYST9;
        up_trip = up_sum[8] ? 8'hFF : up_sum[7:0];
        lo_trip = ({1'b0, thr} < HYST9) ? 8'h00 : (thr - HYST9[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= LVL_LOW;
        end else begin
            lvl <= lvl_nxt;
        end
    end

    // Edge events are decided on the incoming sample so they land in the cycle the sample arrives.
    always_comb begin
        lvl_nxt  = lvl;
        rise_evt = 1'b0;
        fall_evt = 1'b0;
        if (sample_valid) begin
            case (lvl)
                LVL_LOW: begin
                    if (sample_data >= up_trip) begin
                        lvl_nxt  = LVL_HIGH;
                        rise_evt = 1'b1;
                    end
                end
                LVL_HIGH: begin
                    if (sample_data <= lo_trip) begin
                        lvl_nxt  = LVL_LOW;
                        fall_evt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        tmr_inc = (tmr == SAT32) ? SAT32 : (tmr + 32'd1);
        run_nxt = run_q;
        if (rise_evt) begin
            if (run_q.freq != SAT32) begin
                run_nxt.freq = run_q.freq + 32'd1;
            end
            if (rise_seen) begin
                run_nxt.period = tmr_inc;
            end
        end
        if (fall_evt && rise_seen) begin
            run_nxt.high = tmr_inc;
        end
        if (sample_valid) begin
            if (sample_data > run_q.vmax) begin
                run_nxt.vmax = sample_data;
            end
            if (sample_data < run_q.vmin) begin
                run_nxt.vmin = sample_data;
            end
        end
    end

    // Comparator state and tmr deliberately survive the window boundary; only run values clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate       <= '0;
            tmr        <= 32'd0;
            rise_seen  <= 1'b0;
            run_q      <= MEAS_CLR;
            res_q      <= MEAS_CLR;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= window_end;
            tmr        <= rise_evt ? 32'd0 : tmr_inc;
            if (window_end) begin
                gate      <= '0;
                res_q     <= run_nxt;
                run_q     <= MEAS_CLR;
                rise_seen <= 1'b0;
            end else begin
                gate      <= gate + GW'(1);
                run_q     <= run_nxt;
                rise_seen <= rise_seen | rise_evt;
            end
        end
    end

    assign freq_cnt      = res_q.freq;
    assign period_cycles = res_q.period;
    assign high_cycles   = res_q.high;
    assign vmax          = res_q.vmax;
    assign vmin          = res_q.vmin;

endmodule

// File: doc/wave_meter.md
# wave_meter

Measurement block for the waveform path: takes an 8-bit sampled waveform (DDS loopback of `sin_data`/`square_data`, or an external ADC stream) and reports frequency, last period, high time and amplitude extremes once per gate window. Digitises the stream with a hysteresis comparator, times edges in `clk` cycles, and publishes a registered result set with a one-cycle `meas_valid` strobe. Sits beside the DDS generator as its self-check/readback counterpart.

## Interface
- `GATE_CYCLES`, 50_000_000, gate window length in `clk` cycles (≥ 4)
- `HYST`, 8, comparator hysteresis half-width in LSBs (0..63)
- `clk`  input  1  system clock; all logic rising-edge
- `rst`  input  1  synchronous, active-high reset
- `sample_valid`  input  1  `sample_data` qualifier, any duty
- `sample_data`  input  8  unsigned sample, 0x00..0xFF
- `freq_cnt`  output  32  rising edges counted in last window
- `period_cycles`  output  32  clk cycles between last two rising edges of last window; 0 if none
- `high_cycles`  output  32  clk cycles from last rising to following falling edge of last window; 0 if none
- `vmax`  output  8  max sample in last window
- `vmin`  output  8  min sample in last window
- `meas_valid`  output  1  one-cycle pulse: outputs updated

## Operation
- Threshold `thr` (8 bit): 128 after reset; at each window end loads (vmax_run + vmin_run) >> 1 (9-bit sum) if ≥1 sample seen, else unchanged.
- Upper trip = min(thr + HYST, 255); lower trip = max(thr − HYST, 0); 9-bit saturating arithmetic.
- Comparator state `LVL_LOW`/`LVL_HIGH`, reset `LVL_LOW`, updated only on `sample_valid`:
  - LOW → HIGH when sample ≥ upper trip: rising edge event.
  - HIGH → LOW when sample ≤ lower trip: falling edge event.
- Free-running `tmr` (32 bit, saturates 0xFFFF_FFFF) cleared on each rising edge. On rising edge, if a previous rising edge exists in the window, `per_run` ← tmr + 1. On falling edge with a preceding rising edge in window, `hi_run` ← tmr + 1.
- `edge_run` increments per rising edge, saturates at 0xFFFF_FFFF.
- `vmax_run`/`vmin_run` track extremes of valid samples; reset to 0x00/0xFF at window start.
- Gate counter `gate` 0..GATE_CYCLES−1, wraps. On `gate == GATE_CYCLES−1` (window end): events in that cycle count in the closing window; result registers load from run values (including that cycle's event); run registers, "previous rising seen" flag and extremes clear; comparator state and `tmr` persist (edges straddling windows not lost to state, but first period of new window needs two new rising edges).
- Window with no valid samples: vmax = 0x00, vmin = 0xFF.

## Timing
- All outputs registered. Reset: all outputs 0 except `vmin` = 0xFF; `meas_valid` = 0; gate = 0, thr = 128.
- Sample → comparator state: 1 cycle. Window-end cycle N → outputs and `meas_valid` = 1 at cycle N+1; `meas_valid` low otherwise.
- First `meas_valid` exactly GATE_CYCLES cycles after `rst` deasserts.
- `rst` mid-window: abandons window, no `meas_valid`, outputs return to reset values next cycle.
- Simultaneous window end and edge: edge belongs to closing window.

## Configuration
- `WAVE_METER_AUTO_THR_EN` defined: threshold adapts per window as above.
- Undefined: `thr` fixed at 128; extreme tracking still reported; no threshold update logic.

## Test plan
- GATE_CYCLES=1000, square samples 0x00/0xFF every cycle, period 100 (high 30) → freq_cnt=10, period_cycles=100, high_cycles=30, vmax=0xFF, vmin=0x00, meas_valid at cycle 1000 after reset release.
- Sine 0x40..0xC0, 4096-cycle period, GATE_CYCLES=20000 → freq_cnt 4 or 5, period_cycles=4096 ±1, thr→0x80 after first window.
- Samples alternating 0x7C/0x84 (noise inside HYST=8 band) → freq_cnt=0, period_cycles=0, high_cycles=0.
- `sample_valid` held 0 whole window → freq_cnt=0, vmax=0x00, vmin=0xFF, meas_valid still pulses.
- `rst` asserted at gate=500 of 1000 → no pulse at old boundary; next meas_valid 1000 cycles after release.
- Macro off, signal 0x10..0x60 (never ≥ 136) → freq_cnt=0 each window; macro on → second window counts correctly.
